// File: rtl/tt_seq_pkg.sv
// Shared types and helpers for the truth-table sequencer and its dwell timer.
package tt_seq_pkg;

  // Sequencer states; encodings are fixed so they read cleanly in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter width able to hold 0..depth-1, never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts the cycles a stimulus vector has been held; flags the final (check) cycle.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);
  import tt_seq_pkg::*;

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] count;

  assign last = (count == LAST_CNT);

  // Free-running dwell count that wraps after the check cycle so the next vector starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps an N-bit vector through every combination, holding each for DWELL cycles,
// and counts vectors where the two expression outputs of the datapath disagree.
module truth_table_sequencer #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         lhs,
  input  logic         rhs,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);
  import tt_seq_pkg::*;

  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

  state_t       state, state_next;
  logic [N-1:0] vec_next;
  logic         busy_next, done_next, pass_next;
  logic [N:0]   err_cnt_next;
  logic [N-1:0] first_fail_next;
  logic         first_fail_valid_next;
  logic [N:0]   err_sum;
  logic         mismatch;
  logic         timer_clear, timer_en, timer_last;

  assign mismatch = (lhs != rhs);

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .last  (timer_last)
  );

  // Next-state and next-result logic; every register holds unless a transition updates it.
  always_comb begin
    state_next            = state;
    vec_next              = vec;
    busy_next             = busy;
    done_next             = done;
    pass_next             = pass;
    err_cnt_next          = err_cnt;
    first_fail_next       = first_fail;
    first_fail_valid_next = first_fail_valid;
    timer_clear           = 1'b0;
    timer_en              = 1'b0;
    err_sum               = err_cnt + {{N{1'b0}}, mismatch};

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next            = ST_APPLY;
          vec_next              = '0;
          busy_next             = 1'b1;
          done_next             = 1'b0;
          pass_next             = 1'b0;
          err_cnt_next          = '0;
          first_fail_next       = '0;
          first_fail_valid_next = 1'b0;
          timer_clear           = 1'b1;
        end
      end
      ST_APPLY: begin
        timer_en = 1'b1;
        if (timer_last) begin
          err_cnt_next = err_sum;
          if (mismatch && !first_fail_valid) begin
            first_fail_next       = vec;
            first_fail_valid_next = 1'b1;
          end
          if (vec == VEC_LAST) begin
            state_next = ST_DONE;
            vec_next   = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            pass_next  = (err_sum == '0);
          end else begin
            vec_next = vec + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_next;
      vec              <= vec_next;
      busy             <= busy_next;
      done             <= done_next;
      pass             <= pass_next;
      err_cnt          <= err_cnt_next;
      first_fail       <= first_fail_next;
      first_fail_valid <= first_fail_valid_next;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a 3-bit/DWELL=4 instance checking OR associativity
// with injected faults, plus a 2-bit/DWELL=1 instance with identical expressions.
module tb_truth_table_sequencer;

  typedef struct {
    int err;
    int ff;
    int ffv;
    int pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         rhs_mode = 0;

  logic       lhs, rhs;
  logic [2:0] vec;
  logic       busy, done, pass, first_fail_valid;
  logic [3:0] err_cnt;
  logic [2:0] first_fail;

  logic       lhs2, rhs2;
  logic [1:0] vec2;
  logic       busy2, done2, pass2, first_fail_valid2;
  logic [2:0] err_cnt2;
  logic [1:0] first_fail2;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  truth_table_sequencer #(.N(3), .DWELL(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .lhs              (lhs),
    .rhs              (rhs),
    .vec              (vec),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_fail       (first_fail),
    .first_fail_valid (first_fail_valid)
  );

  truth_table_sequencer #(.N(2), .DWELL(1)) dut_small (
    .clk              (clk),
    .rst              (rst),
    .start            (start2),
    .lhs              (lhs2),
    .rhs              (rhs2),
    .vec              (vec2),
    .busy             (busy2),
    .done             (done2),
    .pass             (pass2),
    .err_cnt          (err_cnt2),
    .first_fail       (first_fail2),
    .first_fail_valid (first_fail_valid2)
  );

  // Gate-level datapath under test: (x|y)|z against (y|z)|x with optional fault injection.
  always_comb begin
    lhs = (vec[2] | vec[1]) | vec[0];
    case (rhs_mode)
      1:       rhs = (vec == 3'd3) ? 1'b0 : ((vec[1] | vec[0]) | vec[2]);
      2:       rhs = ~((vec[2] | vec[1]) | vec[0]);
      default: rhs = (vec[1] | vec[0]) | vec[2];
    endcase
  end

  assign lhs2 = vec2[1] ^ vec2[0];
  assign rhs2 = vec2[0] ^ vec2[1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference results for a full sweep of the 3-bit datapath in the given fault mode.
  function automatic exp_t model_sweep(input int mode);
    exp_t e;
    logic [2:0] v;
    logic l, r;
    e = '{err: 0, ff: 0, ffv: 0, pass: 0};
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      l = v[2] | v[1] | v[0];
      case (mode)
        1:       r = (k == 3) ? 1'b0 : (v[2] | v[1] | v[0]);
        2:       r = ~l;
        default: r = v[2] | v[1] | v[0];
      endcase
      if (l != r) begin
        if (e.ffv == 0) begin
          e.ff  = k;
          e.ffv = 1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic popAndCheck(input string tag, input logic [31:0] got_err,
                             input logic [31:0] got_ff, input logic got_ffv,
                             input logic got_pass);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_err_cnt"}, got_err, e.err);
      checkOutput({tag, "_pass"}, {31'd0, got_pass}, e.pass);
      checkOutput({tag, "_ffv"}, {31'd0, got_ffv}, e.ffv);
      if (e.ffv != 0) checkOutput({tag, "_first_fail"}, got_ff, e.ff);
    end
  endtask

  // One sweep of the 3-bit instance; optional start pulses mid-sweep and optional reset abort.
  task automatic applyStimulus(input int mode, input bit pulse_start, input int abort_at);
    rhs_mode = mode;
    if (abort_at < 0) sb.push_back(model_sweep(mode));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checkOutput("sweep_busy", {31'd0, busy}, 1);
      checkOutput("sweep_vec", {29'd0, vec}, c / 4);
      checkOutput("sweep_done", {31'd0, done}, 0);
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 0);
        checkOutput("abort_vec", {29'd0, vec}, 0);
        checkOutput("abort_err_cnt", {28'd0, err_cnt}, 0);
        checkOutput("abort_done", {31'd0, done}, 0);
        return;
      end
      start = pulse_start && (c == 5 || c == 20);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("end_busy", {31'd0, busy}, 0);
    checkOutput("end_done", {31'd0, done}, 1);
    checkOutput("end_vec", {29'd0, vec}, 0);
    popAndCheck("sweep", {28'd0, err_cnt}, {29'd0, first_fail}, first_fail_valid, pass);
  endtask

  // Drive the stimulus sequence and print the summary.
  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_pass", {31'd0, pass}, 0);
    checkOutput("rst_vec", {29'd0, vec}, 0);
    checkOutput("rst_err_cnt", {28'd0, err_cnt}, 0);
    checkOutput("rst_first_fail", {29'd0, first_fail}, 0);
    checkOutput("rst_ffv", {31'd0, first_fail_valid}, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 1'b0, -1);
    applyStimulus(1, 1'b0, -1);
    applyStimulus(2, 1'b0, -1);
    applyStimulus(0, 1'b0, 10);
    applyStimulus(0, 1'b0, -1);
    applyStimulus(0, 1'b1, -1);
    applyStimulus(0, 1'b0, -1);

    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", {31'd0, busy}, 0);
    checkOutput("rst_start_done", {31'd0, done}, 0);
    @(negedge clk);
    checkOutput("rst_start_idle", {31'd0, busy}, 0);

    sb.push_back('{err: 0, ff: 0, ffv: 0, pass: 1});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("small_busy", {31'd0, busy2}, 1);
      checkOutput("small_vec", {30'd0, vec2}, c);
      @(negedge clk);
    end
    checkOutput("small_end_busy", {31'd0, busy2}, 0);
    checkOutput("small_end_done", {31'd0, done2}, 1);
    popAndCheck("small", {29'd0, err_cnt2}, {30'd0, first_fail2}, first_fail_valid2, pass2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
